// File: rtl/mult_pipe.sv
// mult_pipe: pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Each stage adds one CH-bit chunk of the multiplier times the multiplicand
// into a running 2*XLEN sum. Stages have individual valid/ready flow control
// and branch-mask tracking, so mispredicted work dies wherever it sits.
//
// Handshake: a transfer happens on a rising edge when valid and ready are both
// high in the cycle before it. in_ready is ready of stage 0. Upstream may not
// retract in_valid before the transfer. out_valid/out_* are held stable while
// out_valid && !cdb_en. cdb_en is the ready of the last stage. Within a cycle,
// ready may depend combinationally on cdb_en.
module mult_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 6,
  parameter int BM_W   = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_func,
  input  logic [XLEN-1:0]               in_rs1,
  input  logic [XLEN-1:0]               in_rs2,
  input  logic [TAG_W-1:0]              in_tag,
  input  logic [BM_W-1:0]               in_bm,
  input  logic [BM_W-1:0]               b_mm_resolve,
  input  logic                          b_mm_mispred,
  input  logic                          cdb_en,
  output logic                          out_valid,
  output logic [XLEN-1:0]               out_result,
  output logic [TAG_W-1:0]              out_tag,
  output logic [BM_W-1:0]               out_bm,
  output logic [$clog2(STAGES+1)-1:0]   occupancy
);

  localparam int W2    = 2 * XLEN;
  localparam int CH    = W2 / STAGES;
  localparam int LAST  = STAGES - 1;
  localparam int OCC_W = $clog2(STAGES + 1);

  // Stage registers
  logic [STAGES-1:0] valid_q;
  logic [W2-1:0]     mcand_q  [STAGES];
  logic [W2-1:0]     mplier_q [STAGES];
  logic [W2-1:0]     sum_q    [STAGES];
  logic [1:0]        func_q   [STAGES];
  logic [TAG_W-1:0]  tag_q    [STAGES];
  logic [BM_W-1:0]   bm_q     [STAGES];

  // Upstream source of each stage (stage 0 sources the request port)
  logic [STAGES-1:0] src_valid;
  logic [W2-1:0]     src_mcand  [STAGES];
  logic [W2-1:0]     src_mplier [STAGES];
  logic [W2-1:0]     src_sum    [STAGES];
  logic [1:0]        src_func   [STAGES];
  logic [TAG_W-1:0]  src_tag    [STAGES];
  logic [BM_W-1:0]   src_bm     [STAGES];

  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] src_kill;
  logic [STAGES-1:0] hold_kill;
  logic [STAGES-1:0] v_nxt;
  logic [W2-1:0]     sum_nxt    [STAGES];
  logic [OCC_W-1:0]  occ_nxt;
  logic [W2-1:0]     mcand_in;
  logic [W2-1:0]     mplier_in;
  logic              rdy_acc;

  // Operand extension: only MULHU treats rs1 as unsigned; MULHSU/MULHU treat rs2 as unsigned
  always_comb begin
    mcand_in  = (in_func == 2'b11) ? {{XLEN{1'b0}}, in_rs1}
                                   : {{XLEN{in_rs1[XLEN-1]}}, in_rs1};
    mplier_in = in_func[1] ? {{XLEN{1'b0}}, in_rs2}
                           : {{XLEN{in_rs2[XLEN-1]}}, in_rs2};
  end

  // Source mux: request port feeds stage 0, stage i-1 feeds stage i
  always_comb begin
    src_valid     = '0;
    src_valid[0]  = in_valid;
    src_mcand[0]  = mcand_in;
    src_mplier[0] = mplier_in;
    src_sum[0]    = '0;
    src_func[0]   = in_func;
    src_tag[0]    = in_tag;
    src_bm[0]     = in_bm;
    for (int i = 1; i < STAGES; i++) begin
      src_valid[i]  = valid_q[i-1];
      src_mcand[i]  = mcand_q[i-1];
      src_mplier[i] = mplier_q[i-1];
      src_sum[i]    = sum_q[i-1];
      src_func[i]   = func_q[i-1];
      src_tag[i]    = tag_q[i-1];
      src_bm[i]     = bm_q[i-1];
    end
  end

  // Ready chain, kill detection, next valids and the per-stage partial-product add.
  // ready_i = !valid_i || ready_(i+1) is flattened into a running OR from the output end.
  always_comb begin
    rdy       = '0;
    src_kill  = '0;
    hold_kill = '0;
    v_nxt     = '0;
    occ_nxt   = '0;
    rdy_acc   = cdb_en;
    for (int i = LAST; i >= 0; i--) begin
      rdy_acc = rdy_acc || !valid_q[i];
      rdy[i]  = rdy_acc;
    end
    for (int i = 0; i < STAGES; i++) begin
      src_kill[i]  = b_mm_mispred && (|(src_bm[i] & b_mm_resolve));
      hold_kill[i] = b_mm_mispred && (|(bm_q[i] & b_mm_resolve));
      v_nxt[i]     = rdy[i] ? (src_valid[i] && !src_kill[i])
                            : (valid_q[i] && !hold_kill[i]);
      occ_nxt      = occ_nxt + OCC_W'(v_nxt[i]);
      sum_nxt[i]   = src_sum[i]
                   + src_mcand[i] * {{(W2-CH){1'b0}}, src_mplier[i][CH-1:0]};
    end
  end

  // Stage registers: load from upstream when ready, otherwise hold; resolved bits clear everywhere
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q   <= '0;
      occupancy <= '0;
      for (int i = 0; i < STAGES; i++) begin
        mcand_q[i]  <= '0;
        mplier_q[i] <= '0;
        sum_q[i]    <= '0;
        func_q[i]   <= '0;
        tag_q[i]    <= '0;
        bm_q[i]     <= '0;
      end
    end else begin
      valid_q   <= v_nxt;
      occupancy <= occ_nxt;
      for (int i = 0; i < STAGES; i++) begin
        if (rdy[i]) begin
          mcand_q[i]  <= src_mcand[i] << CH;
          mplier_q[i] <= src_mplier[i] >> CH;
          sum_q[i]    <= sum_nxt[i];
          func_q[i]   <= src_func[i];
          tag_q[i]    <= src_tag[i];
          bm_q[i]     <= src_bm[i] & ~b_mm_resolve;
        end else begin
          bm_q[i]     <= bm_q[i] & ~b_mm_resolve;
        end
      end
    end
  end

  // Output stage: masked combinationally by a resolve landing this cycle
  always_comb begin
    in_ready   = rdy[0];
    out_valid  = valid_q[LAST] && !hold_kill[LAST];
    out_result = (func_q[LAST] == 2'b00) ? sum_q[LAST][XLEN-1:0]
                                         : sum_q[LAST][W2-1:XLEN];
    out_tag    = tag_q[LAST];
    out_bm     = bm_q[LAST] & ~b_mm_resolve;
  end

endmodule

// File: tb/tb_mult_pipe.sv
// tb_mult_pipe: directed test of mult_pipe with hand-computed products and an
// in-order expected-result queue checked on every CDB transfer.
module tb_mult_pipe;

  localparam int XLEN   = 32;
  localparam int STAGES = 4;
  localparam int TAG_W  = 6;
  localparam int BM_W   = 4;
  localparam int OCC_W  = 3;

  localparam logic [1:0] F_MUL    = 2'b00;
  localparam logic [1:0] F_MULH   = 2'b01;
  localparam logic [1:0] F_MULHSU = 2'b10;
  localparam logic [1:0] F_MULHU  = 2'b11;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_func;
  logic [XLEN-1:0]   in_rs1;
  logic [XLEN-1:0]   in_rs2;
  logic [TAG_W-1:0]  in_tag;
  logic [BM_W-1:0]   in_bm;
  logic [BM_W-1:0]   b_mm_resolve;
  logic              b_mm_mispred;
  logic              cdb_en;
  logic              out_valid;
  logic [XLEN-1:0]   out_result;
  logic [TAG_W-1:0]  out_tag;
  logic [BM_W-1:0]   out_bm;
  logic [OCC_W-1:0]  occupancy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [TAG_W+XLEN-1:0] exp_q[$];
  logic [TAG_W+XLEN-1:0] mon_ent;

  mult_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W), .BM_W(BM_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag), .in_bm(in_bm),
    .b_mm_resolve(b_mm_resolve), .b_mm_mispred(b_mm_mispred), .cdb_en(cdb_en),
    .out_valid(out_valid), .out_result(out_result), .out_tag(out_tag),
    .out_bm(out_bm), .occupancy(occupancy)
  );

  // Clock / watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Scoreboard: every CDB transfer must match the oldest expected entry
  always @(negedge clock) begin
    if (reset && out_valid && cdb_en) begin
      check("sb_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_ent = exp_q.pop_front();
        check("sb_tag", 64'(out_tag), 64'(mon_ent[TAG_W+XLEN-1:XLEN]));
        check("sb_result", 64'(out_result), 64'(mon_ent[XLEN-1:0]));
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [TAG_W-1:0] t, input logic [XLEN-1:0] r);
    exp_q.push_back({t, r});
  endtask

  task automatic drive(input logic [1:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TAG_W-1:0] t, input logic [BM_W-1:0] m);
    in_valid = 1'b1;
    in_func  = f;
    in_rs1   = a;
    in_rs2   = b;
    in_tag   = t;
    in_bm    = m;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Present a request and hold it until accepted (bounded)
  task automatic send(input logic [1:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [TAG_W-1:0] t, input logic [BM_W-1:0] m);
    drive(f, a, b, t, m);
    @(negedge clock);
    for (int k = 0; k < 50 && !in_ready; k++) begin
      tick();
      @(negedge clock);
    end
    check("send_ready", 64'(in_ready), 64'd1);
    tick();
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) tick();
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset        = 1'b0;
    in_valid     = 1'b0;
    in_func      = '0;
    in_rs1       = '0;
    in_rs2       = '0;
    in_tag       = '0;
    in_bm        = '0;
    b_mm_resolve = '0;
    b_mm_mispred = 1'b0;
    cdb_en       = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_bm", 64'(out_bm), 64'd0);
    #5 reset = 1'b1;

    // Latency and back-to-back throughput
    tick();
    push(6'd1, 32'd15);
    send(F_MUL, 32'd3, 32'd5, 6'd1, 4'd0);
    push(6'd2, 32'hFFFF_FFFA);
    send(F_MUL, 32'hFFFF_FFFE, 32'd3, 6'd2, 4'd0);
    idle();
    tick();
    @(negedge clock);
    check("lat_early_valid", 64'(out_valid), 64'd0);
    tick();
    @(negedge clock);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_result", 64'(out_result), 64'd15);
    tick();
    @(negedge clock);
    check("b2b_valid", 64'(out_valid), 64'd1);
    check("b2b_result", 64'(out_result), 64'hFFFF_FFFA);
    check("b2b_tag", 64'(out_tag), 64'd2);
    wait_drain(10);
    check("occ_idle", 64'(occupancy), 64'd0);

    // High halves of 0xFFFFFFFF x 0xFFFFFFFF
    push(6'd3, 32'h0000_0000);
    send(F_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd3, 4'd0);
    push(6'd4, 32'hFFFF_FFFF);
    send(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd4, 4'd0);
    push(6'd5, 32'hFFFF_FFFE);
    send(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd5, 4'd0);
    idle();
    wait_drain(20);

    // Stall: fill the pipe with the CDB withheld, then release it
    cdb_en = 1'b0;
    push(6'd10, 32'd6);  send(F_MUL, 32'd2, 32'd3, 6'd10, 4'd0);
    push(6'd11, 32'd12); send(F_MUL, 32'd3, 32'd4, 6'd11, 4'd0);
    push(6'd12, 32'd20); send(F_MUL, 32'd4, 32'd5, 6'd12, 4'd0);
    push(6'd13, 32'd30); send(F_MUL, 32'd5, 32'd6, 6'd13, 4'd0);
    push(6'd14, 32'd42);
    drive(F_MUL, 32'd6, 32'd7, 6'd14, 4'd0);
    @(negedge clock);
    check("st_occ_full", 64'(occupancy), 64'd4);
    check("st_ready_full", 64'(in_ready), 64'd0);
    check("st_out_valid", 64'(out_valid), 64'd1);
    check("st_out_tag", 64'(out_tag), 64'd10);
    tick();
    @(negedge clock);
    check("st_hold_result", 64'(out_result), 64'd6);
    check("st_hold_ready", 64'(in_ready), 64'd0);
    tick();
    cdb_en = 1'b1;
    @(negedge clock);
    check("st_freed_ready", 64'(in_ready), 64'd1);
    tick();
    idle();
    wait_drain(20);

    // Mispredict squash of two of three in-flight entries
    push(6'd21, 32'd16);
    send(F_MUL, 32'd3, 32'd3, 6'd20, 4'b0001);
    send(F_MUL, 32'd4, 32'd4, 6'd21, 4'b0010);
    send(F_MUL, 32'd5, 32'd5, 6'd22, 4'b0001);
    idle();
    b_mm_resolve = 4'b0001;
    b_mm_mispred = 1'b1;
    @(negedge clock);
    check("sq_occ_before", 64'(occupancy), 64'd3);
    tick();
    b_mm_resolve = '0;
    b_mm_mispred = 1'b0;
    @(negedge clock);
    check("sq_occ_after", 64'(occupancy), 64'd1);
    wait_drain(10);

    // Correct resolve clears the bit in flight
    push(6'd30, 32'd56);
    send(F_MUL, 32'd7, 32'd8, 6'd30, 4'b0011);
    idle();
    b_mm_resolve = 4'b0010;
    b_mm_mispred = 1'b0;
    tick();
    b_mm_resolve = '0;
    @(negedge clock);
    for (int k = 0; k < 10 && !out_valid; k++) begin
      tick();
      @(negedge clock);
    end
    check("cr_valid", 64'(out_valid), 64'd1);
    check("cr_bm", 64'(out_bm), 64'b0001);
    tick();

    // Accept coinciding with a mispredict on the request's own mask
    drive(F_MUL, 32'd2, 32'd2, 6'd40, 4'b0100);
    b_mm_resolve = 4'b0100;
    b_mm_mispred = 1'b1;
    @(negedge clock);
    check("drop_ready", 64'(in_ready), 64'd1);
    tick();
    idle();
    b_mm_resolve = '0;
    b_mm_mispred = 1'b0;
    @(negedge clock);
    check("drop_occ", 64'(occupancy), 64'd0);
    repeat (6) tick();

    // Asynchronous reset mid-pipe, then a fresh request
    send(F_MUL, 32'd6, 32'd6, 6'd50, 4'd0);
    send(F_MUL, 32'd7, 32'd7, 6'd51, 4'd0);
    idle();
    tick();
    tick();
    check("mid_occ", 64'(occupancy), 64'd2);
    check("mid_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_occ", 64'(occupancy), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    @(negedge clock);
    #2 reset = 1'b1;
    tick();
    push(6'd60, 32'd81);
    send(F_MUL, 32'd9, 32'd9, 6'd60, 4'd0);
    idle();
    tick();
    tick();
    @(negedge clock);
    check("rr_early_valid", 64'(out_valid), 64'd0);
    tick();
    @(negedge clock);
    check("rr_valid", 64'(out_valid), 64'd1);
    check("rr_tag", 64'(out_tag), 64'd60);
    tick();
    wait_drain(5);
    repeat (4) tick();

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_pipe.md
# mult_pipe

Parametrised, pipelined integer multiplier for the execute stage, the next generation of the fixed-width multiplier FU. It covers all four RV32M multiply variants (MUL, MULH, MULHSU, MULHU), returning the low or the high XLEN bits of the 2*XLEN product. Per-stage valid/ready backpressure lets the pipe stall under CDB contention without losing results. Branch-mask tracking clears resolved bits and kills mispredicted work in any stage.

## Interface
Parameters:
- XLEN, 32, operand/result width
- STAGES, 4, pipeline depth; must be ≥2 and divide 2*XLEN
- TAG_W, 6, destination physical-register tag width
- BM_W, 4, branch-mask width

Ports:
- clock  in  1  single clock; everything is rising-edge
- reset  in  1  asynchronous, active-low; all state clears while low
- in_valid  in  1  request present
- in_ready  out  1  stage 0 can accept this cycle
- in_func  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- in_rs1, in_rs2  in  XLEN  operands (rs1 = multiplicand)
- in_tag  in  TAG_W  destination tag
- in_bm  in  BM_W  branch mask of request
- b_mm_resolve  in  BM_W  one-hot resolving branch bit, or zero
- b_mm_mispred  in  1  resolving branch mispredicted
- cdb_en  in  1  CDB grant for the current output
- out_valid  out  1  completed result present (CDB request)
- out_result  out  XLEN  selected product half
- out_tag  out  TAG_W  destination tag of result
- out_bm  out  BM_W  branch mask of result, resolved bit already cleared
- occupancy  out  $clog2(STAGES+1)  registered count of valid stages

## Operation
- Operand extension to 2*XLEN:
  - MUL, MULH, MULHSU: mcand is sign-extended; MULHU: zero-extended.
  - MUL, MULH: mplier is sign-extended; MULHSU, MULHU: zero-extended.
- Product is computed mod 2^(2*XLEN).
- CH = 2*XLEN/STAGES. Stage i adds mcand × mplier[i*CH +: CH], shifted left by i*CH, to the running sum. Each stage register carries the shifted operands, sum, func, tag, bm and valid.
- Result selection: func 00 → sum[XLEN-1:0]; all other funcs → sum[2*XLEN-1:XLEN].
- Flow control:
  - ready_i = !valid_i || ready_(i+1), with ready_STAGES = cdb_en.
  - Stage i loads from stage i-1 (stage 0 from the input) when ready_i. If ready_i and nothing valid arrives, stage i loads a bubble.
  - in_ready = ready_0. This is a combinational chain from cdb_en.
- Branch resolve, applied every cycle to the input and to all stages:
  - Correct prediction: every bm has its b_mm_resolve bit cleared at the edge.
  - Mispredict: any entry with bm & b_mm_resolve ≠ 0 becomes invalid at the edge.
  - An input killed this way counts as accepted: nothing is loaded and no stall results.
- The output stage is combinationally masked:
  - out_valid = valid_last && !(b_mm_mispred && |(bm_last & b_mm_resolve)).
  - out_bm = bm_last & ~b_mm_resolve.
- The output is held stable while out_valid && !cdb_en.
- occupancy = number of valid stage registers after each edge.

## Timing
- Reset low (asynchronous):
  - all stage valids = 0, occupancy = 0, out_valid = 0;
  - in_ready = 1;
  - out_result, out_tag, out_bm = 0.
- Latency: a request accepted in cycle 0 gives out_valid in cycle STAGES, provided there are no stalls.
- Throughput is 1 per cycle while cdb_en stays high.
- A stall (out_valid && !cdb_en) freezes only the stages up to the first bubble; upstream bubbles are compressed. The pipe holds at most STAGES results; when full and stalled, in_ready = 0.
- Simultaneous events in one cycle:
  - cdb_en and a squash of the last stage: the result is not presented, and the stage frees.
  - Accept and mispredict on in_bm: the input is dropped and occupancy does not increment.
- Reset asserted mid-operation discards all in-flight work immediately. The first accept after reset release completes STAGES cycles later.

## Test plan
- Ramp with XLEN=32, STAGES=4, cdb_en=1:
  - 3×5 MUL → result 15 in cycle 4;
  - back-to-back −2×3 MUL → 0xFFFFFFFA one cycle later.
- High halves, operands 0xFFFFFFFF × 0xFFFFFFFF:
  - MULH → 0x00000000;
  - MULHSU → 0xFFFFFFFF;
  - MULHU → 0xFFFFFFFE.
- Stall with cdb_en=0: issue 5 requests → occupancy reaches 4 and in_ready=0. Raise cdb_en → 4 results drain in order with their tags, and the 5th is accepted on the first freed cycle.
- Squash: three in flight, with bm 0001, 0010, 0001. Resolve=0001 with mispred=1 → only the 0010 entry completes and occupancy drops by 2.
- Correct resolve: resolve=0010 with mispred=0 while an entry with bm 0011 is in flight → it completes with out_bm=0001.
- Async reset: assert reset low mid-pipe, off a clock edge → out_valid=0, occupancy=0 and in_ready=1 immediately. No stale result appears after reset release.
